// File: rtl/lsu_xlen.sv
// lsu_xlen: parametrised RISC-V load/store unit (XLEN = 32 or 64).
//
// Accepts one memory op per request and decodes funct3 for the configured
// XLEN. It issues one (or, when split, two) commands on an XLEN-wide memory
// bus with byte strobes, then returns one response per request. Load data is
// sign- or zero-extended before it is returned.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   req_*               request from execute (valid/ready, store, funct3,
//                       byte address, right-aligned store data, rd tag)
//   mem_*               bus command (valid/ready, write, aligned address,
//                       lane-shifted data, strobes) and return channel
//                       (mem_rvalid/mem_rdata, one beat per accepted command)
//   resp_*              response (valid/ready, extended data, rd tag, fault)
//   dbg_state           current FSM state, for observation only
//
// Configuration
//   LSU_MISALIGN_SPLIT_EN  when defined, a misaligned access is performed
//   instead of faulting. An access that crosses an XLEN word is split into
//   two bus commands (CMD/WAIT, then CMD2/WAIT2). When undefined, every
//   misaligned access faults with 01 and never reaches the bus.
//
// Handshakes: every valid/ready pair transfers on a rising clk edge where
// both are high; the source holds its payload stable while valid && !ready.
module lsu_xlen #(
  parameter int XLEN = 32,
  parameter int AW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [AW-1:0]     req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_write,
  output logic [AW-1:0]     mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_strb,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_data,
  output logic [4:0]        resp_rd,
  output logic [1:0]        resp_fault,
  output logic [2:0]        dbg_state
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    WAIT  = 3'd2,
    CMD2  = 3'd3,
    WAIT2 = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t state, state_n;

  logic            store_q;
  logic [2:0]      f3_q;
  logic [OW-1:0]   off_q;

  // Decode of the incoming request
  logic [1:0]      size;       // log2 of access size in bytes
  logic [OW-1:0]   off;        // byte lane of the first byte
  logic [NB-1:0]   size_strb;  // size-many ones at lane 0
  logic            illegal;
  logic            fault_mis;  // misaligned and not performable
  logic [XLEN-1:0] lo_wdata;
  logic [NB-1:0]   lo_strb;
  logic [XLEN-1:0] load_shifted;
  logic [XLEN-1:0] load_ext;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic              cross;
  logic              cross_q;
  logic [2*XLEN-1:0] wide_wdata;
  logic [2*NB-1:0]   wide_strb;
  logic [XLEN-1:0]   hi_wdata, hi_wdata_q;
  logic [NB-1:0]     hi_strb, hi_strb_q;
  logic [XLEN-1:0]   lo_rdata_q;
  logic [2*XLEN-1:0] merged;
`endif

  always_comb begin
    size      = req_funct3[1:0];
    off       = req_addr[OW-1:0];
    size_strb = NB'((1 << (1 << size)) - 1);
    if (req_store) begin
      if (XLEN == 64) illegal = (req_funct3 > 3'b011);
      else            illegal = (req_funct3 > 3'b010);
    end else begin
      if (XLEN == 64) illegal = (req_funct3 == 3'b111);
      else            illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                                (req_funct3 == 3'b111);
    end
`ifdef LSU_MISALIGN_SPLIT_EN
    fault_mis  = 1'b0;
    // A request crosses into the next word when its last byte lies past lane NB-1.
    cross      = (int'(off) + (1 << size)) > NB;
    wide_wdata = {{XLEN{1'b0}}, req_wdata} << {off, 3'b000};
    wide_strb  = {{NB{1'b0}}, size_strb} << off;
    lo_wdata   = wide_wdata[XLEN-1:0];
    hi_wdata   = wide_wdata[2*XLEN-1:XLEN];
    lo_strb    = wide_strb[NB-1:0];
    hi_strb    = wide_strb[2*NB-1:NB];
`else
    fault_mis  = (off & OW'((1 << size) - 1)) != '0;
    lo_wdata   = req_wdata << {off, 3'b000};
    lo_strb    = size_strb << off;
`endif
  end

  // Load path: bytes are merged (split case) and shifted down before extension.
  always_comb begin
`ifdef LSU_MISALIGN_SPLIT_EN
    if (state == WAIT2) merged = {mem_rdata, lo_rdata_q};
    else                merged = {{XLEN{1'b0}}, mem_rdata};
    load_shifted = XLEN'(merged >> {off_q, 3'b000});
`else
    load_shifted = mem_rdata >> {off_q, 3'b000};
`endif
    case (f3_q)
      3'b000:  load_ext = XLEN'($signed(load_shifted[7:0]));
      3'b001:  load_ext = XLEN'($signed(load_shifted[15:0]));
      3'b010:  load_ext = XLEN'($signed(load_shifted[31:0]));
      3'b100:  load_ext = XLEN'(load_shifted[7:0]);
      3'b101:  load_ext = XLEN'(load_shifted[15:0]);
      3'b110:  load_ext = XLEN'(load_shifted[31:0]);
      default: load_ext = load_shifted;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    req_ready  = 1'b0;
    mem_valid  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_n = (illegal || fault_mis) ? RESP : CMD;
      end
      CMD: begin
        mem_valid = 1'b1;
        if (mem_ready) state_n = WAIT;
      end
      WAIT: begin
`ifdef LSU_MISALIGN_SPLIT_EN
        if (mem_rvalid) state_n = cross_q ? CMD2 : RESP;
`else
        if (mem_rvalid) state_n = RESP;
`endif
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      CMD2: begin
        mem_valid = 1'b1;
        if (mem_ready) state_n = WAIT2;
      end
      WAIT2: begin
        if (mem_rvalid) state_n = RESP;
      end
`endif
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store_q    <= 1'b0;
      f3_q       <= 3'b000;
      off_q      <= '0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_strb   <= '0;
      resp_data  <= '0;
      resp_rd    <= '0;
      resp_fault <= 2'b00;
`ifdef LSU_MISALIGN_SPLIT_EN
      cross_q    <= 1'b0;
      hi_wdata_q <= '0;
      hi_strb_q  <= '0;
      lo_rdata_q <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            store_q    <= req_store;
            f3_q       <= req_funct3;
            off_q      <= off;
            resp_rd    <= req_rd;
            mem_write  <= req_store;
            mem_addr   <= {req_addr[AW-1:OW], {OW{1'b0}}};
            mem_wdata  <= lo_wdata;
            mem_strb   <= lo_strb;
            resp_data  <= '0;
            resp_fault <= illegal ? 2'b10 : (fault_mis ? 2'b01 : 2'b00);
`ifdef LSU_MISALIGN_SPLIT_EN
            cross_q    <= cross;
            hi_wdata_q <= hi_wdata;
            hi_strb_q  <= hi_strb;
`endif
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            // For a split load this value is provisional; WAIT2 overwrites it.
            if (!store_q) resp_data <= load_ext;
`ifdef LSU_MISALIGN_SPLIT_EN
            if (cross_q) begin
              lo_rdata_q <= mem_rdata;
              mem_addr   <= mem_addr + AW'(NB);
              mem_wdata  <= hi_wdata_q;
              mem_strb   <= hi_strb_q;
            end
`endif
          end
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        WAIT2: begin
          if (mem_rvalid && !store_q) resp_data <= load_ext;
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_xlen.sv
// tb_lsu_xlen: directed bench for lsu_xlen. One XLEN=32 instance is driven
// from a table of vectors. One XLEN=64 instance covers the 64-bit ops. A few
// hand-written sequences cover bus stalls, stray mem_rvalid and mid-op reset.
`timescale 1ns/1ps
module tb_lsu_xlen;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- XLEN=32 instance ----------------
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_valid, mem_ready, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_strb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic [1:0]  resp_fault;
  logic [2:0]  dbg_state;

  lsu_xlen #(.XLEN(32), .AW(32)) u_lsu32 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_strb(mem_strb),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_fault(resp_fault), .dbg_state(dbg_state)
  );

  // ---------------- XLEN=64 instance ----------------
  logic        w_req_valid, w_req_ready, w_req_store;
  logic [2:0]  w_req_funct3;
  logic [31:0] w_req_addr;
  logic [63:0] w_req_wdata;
  logic [4:0]  w_req_rd;
  logic        w_mem_valid, w_mem_ready, w_mem_write;
  logic [31:0] w_mem_addr;
  logic [63:0] w_mem_wdata;
  logic [7:0]  w_mem_strb;
  logic        w_mem_rvalid;
  logic [63:0] w_mem_rdata;
  logic        w_resp_valid, w_resp_ready;
  logic [63:0] w_resp_data;
  logic [4:0]  w_resp_rd;
  logic [1:0]  w_resp_fault;
  logic [2:0]  w_dbg_state;

  lsu_xlen #(.XLEN(64), .AW(32)) u_lsu64 (
    .clk(clk), .rst(rst),
    .req_valid(w_req_valid), .req_ready(w_req_ready), .req_store(w_req_store),
    .req_funct3(w_req_funct3), .req_addr(w_req_addr), .req_wdata(w_req_wdata), .req_rd(w_req_rd),
    .mem_valid(w_mem_valid), .mem_ready(w_mem_ready), .mem_write(w_mem_write),
    .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .mem_strb(w_mem_strb),
    .mem_rvalid(w_mem_rvalid), .mem_rdata(w_mem_rdata),
    .resp_valid(w_resp_valid), .resp_ready(w_resp_ready), .resp_data(w_resp_data),
    .resp_rd(w_resp_rd), .resp_fault(w_resp_fault), .dbg_state(w_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] lo;      // memory word at the aligned address
    logic [31:0] hi;      // memory word at the next address
    logic [1:0]  fault;
    logic [31:0] data;
    int          ncmd;    // bus commands expected
    int          lat;     // cycles from accept to resp_valid
    logic [31:0] c_addr;  // first command address
    logic [3:0]  c_strb;  // first command strobes (stores)
    logic [31:0] c_wdata; // first command data (stores)
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic store, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                              input logic [31:0] lo, input logic [31:0] hi, input logic [1:0] fault,
                              input logic [31:0] data, input int ncmd, input int lat,
                              input logic [31:0] c_addr, input logic [3:0] c_strb,
                              input logic [31:0] c_wdata);
    vec_t v;
    v.name = name; v.store = store; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd;
    v.lo = lo; v.hi = hi; v.fault = fault; v.data = data; v.ncmd = ncmd; v.lat = lat;
    v.c_addr = c_addr; v.c_strb = c_strb; v.c_wdata = c_wdata;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic handshake32(input string name);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({name, " resp_valid after handshake"}, resp_valid, 1'b0);
    check({name, " req_ready after handshake"}, req_ready, 1'b1);
  endtask

  task automatic apply32(input vec_t v);
    int cyc, ncmd, lat;
    logic pend;
    logic [31:0] pend_addr, c_addr, c_wdata, exp;
    logic [3:0] c_strb;
    logic c_write;
    exp_q.push_back(v.data);
    @(negedge clk);
    check({v.name, " req_ready idle"}, req_ready, 1'b1);
    req_valid = 1'b1; req_store = v.store; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata; req_rd = v.rd;
    @(negedge clk);
    // Scramble the request fields so only captured values can reach the outputs.
    req_valid = 1'b0; req_store = ~v.store; req_funct3 = 3'($urandom_range(0, 7));
    req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom_range(0, 31));
    cyc = 1; ncmd = 0; lat = 0; pend = 1'b0; pend_addr = '0;
    c_addr = '0; c_wdata = '0; c_strb = '0; c_write = 1'b0;
    while (lat == 0 && cyc < 40) begin
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (resp_valid) lat = cyc;
      else if (mem_valid) begin
        if (ncmd == 0) begin
          c_addr = mem_addr; c_wdata = mem_wdata; c_strb = mem_strb; c_write = mem_write;
        end
        ncmd++;
        mem_ready = 1'b1; pend = 1'b1; pend_addr = mem_addr;
      end else if (pend) begin
        mem_rvalid = 1'b1;
        mem_rdata  = (pend_addr == {v.addr[31:2], 2'b00}) ? v.lo : v.hi;
        pend = 1'b0;
      end
      if (lat == 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    exp = exp_q.pop_front();
    if (lat == 0) begin
      check({v.name, " response timeout"}, 1'b0, 1'b1);
    end else begin
      check({v.name, " resp_fault"}, resp_fault, v.fault);
      check({v.name, " resp_data"}, resp_data, exp);
      check({v.name, " resp_rd"}, resp_rd, v.rd);
      check({v.name, " latency"}, lat, v.lat);
      check({v.name, " bus commands"}, ncmd, v.ncmd);
      if (v.ncmd > 0) begin
        check({v.name, " mem_addr"}, c_addr, v.c_addr);
        check({v.name, " mem_write"}, c_write, v.store);
        if (v.store) begin
          check({v.name, " mem_strb"}, c_strb, v.c_strb);
          check({v.name, " mem_wdata"}, c_wdata, v.c_wdata);
        end
      end
      handshake32(v.name);
    end
  endtask

  task automatic op64(input string name, input logic store, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [63:0] wdata, input logic [63:0] rdata,
                      input logic [63:0] exp_data, input logic [1:0] exp_fault, input int exp_ncmd,
                      input logic [31:0] exp_addr, input logic [7:0] exp_strb,
                      input logic [63:0] exp_wdata, input int hold);
    int cyc, ncmd;
    logic got, pend;
    logic [31:0] c_addr;
    logic [7:0] c_strb;
    logic [63:0] c_wdata;
    @(negedge clk);
    w_req_valid = 1'b1; w_req_store = store; w_req_funct3 = f3;
    w_req_addr = addr; w_req_wdata = wdata; w_req_rd = 5'd9;
    @(negedge clk);
    w_req_valid = 1'b0; w_req_addr = $urandom; w_req_wdata = {$urandom, $urandom};
    cyc = 1; ncmd = 0; got = 1'b0; pend = 1'b0;
    c_addr = '0; c_strb = '0; c_wdata = '0;
    while (!got && cyc < 40) begin
      w_mem_ready = 1'b0; w_mem_rvalid = 1'b0;
      if (w_resp_valid) got = 1'b1;
      else if (w_mem_valid) begin
        if (ncmd == 0) begin
          c_addr = w_mem_addr; c_strb = w_mem_strb; c_wdata = w_mem_wdata;
        end
        ncmd++;
        w_mem_ready = 1'b1; pend = 1'b1;
      end else if (pend) begin
        w_mem_rvalid = 1'b1; w_mem_rdata = rdata; pend = 1'b0;
      end
      if (!got) begin
        @(negedge clk);
        cyc++;
      end
    end
    w_mem_ready = 1'b0; w_mem_rvalid = 1'b0;
    if (!got) begin
      check({name, " response timeout"}, 1'b0, 1'b1);
    end else begin
      check({name, " resp_fault"}, w_resp_fault, exp_fault);
      check({name, " resp_data"}, w_resp_data, exp_data);
      check({name, " resp_rd"}, w_resp_rd, 5'd9);
      check({name, " bus commands"}, ncmd, exp_ncmd);
      if (exp_ncmd > 0) check({name, " mem_addr"}, c_addr, exp_addr);
      if (store && exp_ncmd > 0) begin
        check({name, " mem_strb"}, c_strb, exp_strb);
        check({name, " mem_wdata"}, c_wdata, exp_wdata);
      end
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({name, " held resp_valid"}, w_resp_valid, 1'b1);
        check({name, " held resp_data"}, w_resp_data, exp_data);
      end
      w_resp_ready = 1'b1;
      @(negedge clk);
      w_resp_ready = 1'b0;
      check({name, " req_ready after handshake"}, w_req_ready, 1'b1);
    end
  endtask

  // ---------------- main test ----------------
  initial begin
    int k;
    rst = 1'b1;
    req_valid = 0; req_store = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0; resp_ready = 0;
    w_req_valid = 0; w_req_store = 0; w_req_funct3 = 0; w_req_addr = 0; w_req_wdata = 0; w_req_rd = 0;
    w_mem_ready = 0; w_mem_rvalid = 0; w_mem_rdata = 0; w_resp_ready = 0;

    // Vector table (XLEN=32).
    //            name          st f3     addr          wdata         rd  lo            hi            flt    data          n  lat c_addr        strb     c_wdata
    vecs.push_back(mk("lb_neg",   0, 3'b000, 32'h0000_1003, 32'h0,        5'd1, 32'h80FF_1234, 32'h0,       2'b00, 32'hFFFF_FF80, 1, 3, 32'h0000_1000, 4'b0000, 32'h0));
    vecs.push_back(mk("sh_off2",  1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 5'd2, 32'h0,       32'h0,       2'b00, 32'h0,         1, 3, 32'h0000_2000, 4'b1100, 32'hBEEF_0000));
    vecs.push_back(mk("ld_ill32", 0, 3'b011, 32'h0000_1000, 32'h0,        5'd3, 32'h0,         32'h0,       2'b10, 32'h0,         0, 1, 32'h0,         4'b0000, 32'h0));
    vecs.push_back(mk("lbu",      0, 3'b100, 32'h0000_1003, 32'h0,        5'd4, 32'h80FF_1234, 32'h0,       2'b00, 32'h0000_0080, 1, 3, 32'h0000_1000, 4'b0000, 32'h0));
    vecs.push_back(mk("lh_neg",   0, 3'b001, 32'h0000_1002, 32'h0,        5'd5, 32'h80FF_1234, 32'h0,       2'b00, 32'hFFFF_80FF, 1, 3, 32'h0000_1000, 4'b0000, 32'h0));
    vecs.push_back(mk("lhu",      0, 3'b101, 32'h0000_1000, 32'h0,        5'd6, 32'h80FF_1234, 32'h0,       2'b00, 32'h0000_1234, 1, 3, 32'h0000_1000, 4'b0000, 32'h0));
    vecs.push_back(mk("lb_pos",   0, 3'b000, 32'h0000_1001, 32'h0,        5'd7, 32'h80FF_1234, 32'h0,       2'b00, 32'h0000_0012, 1, 3, 32'h0000_1000, 4'b0000, 32'h0));
    vecs.push_back(mk("lw",       0, 3'b010, 32'h0000_1004, 32'h0,        5'd8, 32'hDEAD_BEEF, 32'h0,       2'b00, 32'hDEAD_BEEF, 1, 3, 32'h0000_1004, 4'b0000, 32'h0));
    vecs.push_back(mk("sb_off1",  1, 3'b000, 32'h0000_3001, 32'h1234_56AB, 5'd10, 32'h0,      32'h0,       2'b00, 32'h0,         1, 3, 32'h0000_3000, 4'b0010, 32'h3456_AB00));
    vecs.push_back(mk("sw",       1, 3'b010, 32'h0000_3000, 32'hCAFE_F00D, 5'd11, 32'h0,      32'h0,       2'b00, 32'h0,         1, 3, 32'h0000_3000, 4'b1111, 32'hCAFE_F00D));
    vecs.push_back(mk("st_ill",   1, 3'b011, 32'h0000_3000, 32'h1,        5'd12, 32'h0,       32'h0,       2'b10, 32'h0,         0, 1, 32'h0,         4'b0000, 32'h0));
    vecs.push_back(mk("ld_ill110",0, 3'b110, 32'h0000_1000, 32'h0,        5'd13, 32'h0,       32'h0,       2'b10, 32'h0,         0, 1, 32'h0,         4'b0000, 32'h0));
    vecs.push_back(mk("ld_ill111",0, 3'b111, 32'h0000_1001, 32'h0,        5'd14, 32'h0,       32'h0,       2'b10, 32'h0,         0, 1, 32'h0,         4'b0000, 32'h0));
`ifdef LSU_MISALIGN_SPLIT_EN
    vecs.push_back(mk("lw_cross", 0, 3'b010, 32'h0000_1001, 32'h0,        5'd15, 32'h4433_2211, 32'h8877_6655, 2'b00, 32'h5544_3322, 2, 5, 32'h0000_1000, 4'b0000, 32'h0));
    vecs.push_back(mk("lh_inword",0, 3'b001, 32'h0000_1001, 32'h0,        5'd16, 32'h80FF_1234, 32'h0,       2'b00, 32'hFFFF_FF12, 1, 3, 32'h0000_1000, 4'b0000, 32'h0));
    vecs.push_back(mk("sh_cross", 1, 3'b001, 32'h0000_2003, 32'h0000_BEEF, 5'd17, 32'h0,      32'h0,       2'b00, 32'h0,         2, 5, 32'h0000_2000, 4'b1000, 32'hEF00_0000));
`else
    vecs.push_back(mk("lw_mis",   0, 3'b010, 32'h0000_1001, 32'h0,        5'd15, 32'h4433_2211, 32'h8877_6655, 2'b01, 32'h0,         0, 1, 32'h0,         4'b0000, 32'h0));
    vecs.push_back(mk("lh_mis",   0, 3'b001, 32'h0000_1001, 32'h0,        5'd16, 32'h80FF_1234, 32'h0,       2'b01, 32'h0,         0, 1, 32'h0,         4'b0000, 32'h0));
    vecs.push_back(mk("sh_mis",   1, 3'b001, 32'h0000_2003, 32'h0000_BEEF, 5'd17, 32'h0,      32'h0,       2'b01, 32'h0,         0, 1, 32'h0,         4'b0000, 32'h0));
`endif

    // Reset values, sampled with reset held.
    repeat (3) @(negedge clk);
    check("reset req_ready", req_ready, 1'b1);
    check("reset mem_valid", mem_valid, 1'b0);
    check("reset mem_write", mem_write, 1'b0);
    check("reset resp_valid", resp_valid, 1'b0);
    check("reset mem_addr", mem_addr, 32'h0);
    check("reset mem_wdata", mem_wdata, 32'h0);
    check("reset mem_strb", mem_strb, 4'h0);
    check("reset resp_data", resp_data, 32'h0);
    check("reset resp_rd", resp_rd, 5'h0);
    check("reset resp_fault", resp_fault, 2'b00);
    check("reset state", dbg_state, 3'd0);
    check("reset w_resp_data", w_resp_data, 64'h0);
    check("reset w_mem_strb", w_mem_strb, 8'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) apply32(vecs[i]);

    // Bus stall: command must stay stable while mem_ready is low.
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_1008; req_rd = 5'd20;
    @(negedge clk);
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF;
    k = $urandom_range(2, 4);
    for (int i = 0; i < k; i++) begin
      check("stall mem_valid", mem_valid, 1'b1);
      check("stall mem_addr", mem_addr, 32'h0000_1008);
      @(negedge clk);
    end
    check("stall mem_valid last", mem_valid, 1'b1);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    check("stall mem_valid drops", mem_valid, 1'b0);
    mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("stall resp_valid", resp_valid, 1'b1);
    check("stall resp_data", resp_data, 32'h0BAD_F00D);
    check("stall resp_rd", resp_rd, 5'd20);
    handshake32("stall");

    // Stray mem_rvalid while idle is ignored.
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    repeat (2) @(negedge clk);
    mem_rvalid = 1'b0;
    check("stray rvalid resp_valid", resp_valid, 1'b0);
    check("stray rvalid req_ready", req_ready, 1'b1);

    // Reset while waiting for read data abandons the op.
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_1000; req_rd = 5'd21;
    @(negedge clk);
    req_valid = 1'b0;
    check("rstwait mem_valid", mem_valid, 1'b1);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    check("rstwait in WAIT", dbg_state, 3'd2);
    rst = 1'b1;
    @(negedge clk);
    check("rstwait mem_valid", mem_valid, 1'b0);
    check("rstwait resp_valid", resp_valid, 1'b0);
    check("rstwait req_ready", req_ready, 1'b1);
    check("rstwait mem_addr", mem_addr, 32'h0);
    check("rstwait resp_rd", resp_rd, 5'h0);
    rst = 1'b0;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'h2222_2222;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rstwait late rvalid resp_valid", resp_valid, 1'b0);
      @(negedge clk);
    end
    check("rstwait req_ready idle", req_ready, 1'b1);

    // XLEN=64 ops.
    op64("lwu64", 1'b0, 3'b110, 32'h8, 64'h0, 64'hFFFF_FFFF_F000_0001, 64'h0000_0000_F000_0001,
         2'b00, 1, 32'h8, 8'h00, 64'h0, 5);
    op64("lw64_hi", 1'b0, 3'b010, 32'hC, 64'h0, 64'h8000_0000_1234_5678, 64'hFFFF_FFFF_8000_0000,
         2'b00, 1, 32'h8, 8'h00, 64'h0, 0);
    op64("ld64", 1'b0, 3'b011, 32'h10, 64'h0, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788,
         2'b00, 1, 32'h10, 8'h00, 64'h0, 0);
    op64("sd64", 1'b1, 3'b011, 32'h18, 64'hA5A5_0000_5A5A_FFFF, 64'h0, 64'h0,
         2'b00, 1, 32'h18, 8'hFF, 64'hA5A5_0000_5A5A_FFFF, 0);
    op64("sw64_hi", 1'b1, 3'b010, 32'h1C, 64'h0000_0000_CAFE_BABE, 64'h0, 64'h0,
         2'b00, 1, 32'h18, 8'hF0, 64'hCAFE_BABE_0000_0000, 0);
    op64("ld64_ill", 1'b0, 3'b111, 32'h10, 64'h0, 64'h0, 64'h0, 2'b10, 0, 32'h0, 8'h00, 64'h0, 0);
    op64("st64_ill", 1'b1, 3'b100, 32'h10, 64'h1, 64'h0, 64'h0, 2'b10, 0, 32'h0, 8'h00, 64'h0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
